fir_mc_engine: RTL and testbench

Parametrised successor to the single-channel FIR datapath. It is a time-multiplexed, multi-channel FIR filter. A single multiply-accumulate unit serves CHANNELS independent sample histories. Samples arrive over a valid/ready input. Coefficients are held in a writable register bank, and each result appears as a one-cycle out_valid pulse. The block sits between the sample source (ADC/UART front end) and the output sink. The FSM that sequences it is internal.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_mac.sv | 52 +++++
 rtl/fir_mc_engine.sv | 152 +++++++++++++++
 tb/tb_fir_mc_engine.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared FSM state type and width helpers for fir_mc_engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_e;

  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [63:0] smax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] smin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_mac.sv
// ============================================================================
// Module   : fir_mac
// Purpose  : Combinational signed multiply-accumulate step; clamps to the
//            accumulator range when FIR_SAT_EN is defined, otherwise wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_mac
  import fir_pkg::*;
#(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 36
) (
  input  logic signed [WIDTH_OUT-1:0] acc_i,
  input  logic signed [WIDTH_IN-1:0]  coef_i,
  input  logic signed [WIDTH_IN-1:0]  samp_i,
  output logic signed [WIDTH_OUT-1:0] acc_o,
  output logic                        clamp_o
);

  logic signed [2*WIDTH_IN-1:0] w_prod;
  logic signed [WIDTH_OUT-1:0]  w_prod_ext;

  assign w_prod     = coef_i * samp_i;
  assign w_prod_ext = WIDTH_OUT'(w_prod);

`ifdef FIR_SAT_EN
  localparam logic signed [WIDTH_OUT-1:0] SAT_MAX = WIDTH_OUT'(smax(WIDTH_OUT));
  localparam logic signed [WIDTH_OUT-1:0] SAT_MIN = WIDTH_OUT'(smin(WIDTH_OUT));

  logic [WIDTH_OUT:0] w_sum;

  // One guard bit: overflow shows up as disagreement of the top two bits.
  assign w_sum = {acc_i[WIDTH_OUT-1], acc_i} + {w_prod_ext[WIDTH_OUT-1], w_prod_ext};

  always_comb begin
    acc_o   = w_sum[WIDTH_OUT-1:0];
    clamp_o = 1'b0;
    if (w_sum[WIDTH_OUT] != w_sum[WIDTH_OUT-1]) begin
      clamp_o = 1'b1;
      acc_o   = w_sum[WIDTH_OUT] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign acc_o   = acc_i + w_prod_ext;
  assign clamp_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/fir_mc_engine.sv
// ============================================================================
// Module   : fir_mc_engine
// Purpose  : Time-multiplexed multi-channel FIR; one MAC serves all channel
//            histories. Optional saturation is enabled by FIR_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_mc_engine
  import fir_pkg::*;
#(
  parameter  int TAPS      = 16,
  parameter  int WIDTH_IN  = 16,
  parameter  int WIDTH_OUT = 36,
  parameter  int CHANNELS  = 2,
  localparam int CW        = chw(CHANNELS),
  localparam int AW        = $clog2(TAPS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH_IN-1:0]  in_data,
  input  logic        [CW-1:0]        in_ch,
  input  logic                        coef_we,
  input  logic        [AW-1:0]        coef_addr,
  input  logic signed [WIDTH_IN-1:0]  coef_data,
  output logic                        out_valid,
  output logic signed [WIDTH_OUT-1:0] out_data,
  output logic        [CW-1:0]        out_ch,
  output logic                        busy,
  output logic                        sat_flag
);

  fir_state_e state_q, state_d;

  logic signed [WIDTH_IN-1:0]  buf_q  [CHANNELS][TAPS];
  logic signed [WIDTH_IN-1:0]  coef_q [TAPS];
  logic        [AW-1:0]        wp_q   [CHANNELS];
  logic        [CW-1:0]        ch_q;
  logic        [AW-1:0]        k_q;
  logic signed [WIDTH_OUT-1:0] acc_q;
  logic signed [WIDTH_OUT-1:0] out_data_q;
  logic        [CW-1:0]        out_ch_q;

  logic                        w_accept;
  logic                        w_ch_ok;
  logic                        w_start;
  logic                        w_last;
  logic        [AW-1:0]        w_wp;
  logic        [AW-1:0]        w_idx;
  logic signed [WIDTH_OUT-1:0] w_acc_next;
  logic                        w_clamp;

  assign w_accept = in_valid & in_ready;
  assign w_ch_ok  = int'(in_ch) < CHANNELS;
  assign w_start  = w_accept & w_ch_ok;
  assign w_last   = (k_q == AW'(TAPS - 1));

  // Tap k reads the sample written k accepts ago on this channel.
  assign w_wp  = wp_q[ch_q];
  assign w_idx = (k_q <= w_wp) ? (w_wp - k_q) : AW'(int'(w_wp) + TAPS - int'(k_q));

  fir_mac #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT)
  ) u_mac (
    .acc_i   (acc_q),
    .coef_i  (coef_q[k_q]),
    .samp_i  (buf_q[ch_q][w_idx]),
    .acc_o   (w_acc_next),
    .clamp_o (w_clamp)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_start) state_d = MAC;
      MAC:     if (w_last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && rst;
    out_valid = (state_q == DONE);
    busy      = (state_q == MAC) || (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wp_q[c] <= '0;
        for (int t = 0; t < TAPS; t++) buf_q[c][t] <= '0;
      end
      for (int t = 0; t < TAPS; t++) coef_q[t] <= '0;
      ch_q       <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
    end else begin
      if (coef_we && !busy) coef_q[coef_addr] <= coef_data;
      case (state_q)
        IDLE: begin
          if (w_start) begin
            buf_q[in_ch][wp_q[in_ch]] <= in_data;
            ch_q  <= in_ch;
            acc_q <= '0;
            k_q   <= '0;
          end
        end
        MAC: begin
          acc_q <= w_acc_next;
          k_q   <= k_q + AW'(1);
          if (w_last) begin
            out_data_q <= w_acc_next;
            out_ch_q   <= ch_q;
          end
        end
        DONE: wp_q[ch_q] <= (w_wp == AW'(TAPS - 1)) ? '0 : w_wp + AW'(1);
        default: ;
      endcase
    end
  end

  assign out_data = out_data_q;
  assign out_ch   = out_ch_q;

`ifdef FIR_SAT_EN
  logic sat_q;

  always_ff @(posedge clk) begin
    if (!rst)                         sat_q <= 1'b0;
    else if (state_q == MAC && w_clamp) sat_q <= 1'b1;
  end

  assign sat_flag = sat_q;
`else
  // The wrapping MAC ties its clamp bit low, so this is a constant 0.
  assign sat_flag = w_clamp;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir_mc_engine.sv
// ============================================================================
// Module   : tb_fir_mc_engine
// Purpose  : Self-checking bench for fir_mc_engine (TAPS=4, 8-bit in, 20-bit
//            out, 2 channels) plus a 16-bit-output instance; FIR_SAT_EN aware.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_mc_engine;

  localparam int TAPS = 4;
  localparam int WI   = 8;
  localparam int WO   = 20;
  localparam int CH   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [7:0] in_data = '0;
  logic [0:0]        in_ch = '0;
  logic              coef_we = 1'b0;
  logic [1:0]        coef_addr = '0;
  logic signed [7:0] coef_data = '0;

  logic              in_ready, out_valid, busy, sat_flag;
  logic signed [19:0] out_data;
  logic [0:0]        out_ch;
  logic              in_ready16, out_valid16, busy16, sat_flag16;
  logic signed [15:0] out_data16;
  logic [0:0]        out_ch16;

  fir_mc_engine #(.TAPS(TAPS), .WIDTH_IN(WI), .WIDTH_OUT(WO), .CHANNELS(CH)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ch(in_ch), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .busy(busy),
    .sat_flag(sat_flag)
  );

  fir_mc_engine #(.TAPS(TAPS), .WIDTH_IN(WI), .WIDTH_OUT(16), .CHANNELS(CH)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
    .in_ch(in_ch), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid16), .out_data(out_data16), .out_ch(out_ch16), .busy(busy16),
    .sat_flag(sat_flag16)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int r_lat, r_data, r_ch, r_data16, r_sat16;

  int c1234 [TAPS] = '{1, 2, 3, 4};
  int cm128 [TAPS] = '{-128, -128, -128, -128};
  int c127  [TAPS] = '{127, 127, 127, 127};

  // Reference model: coefficient list and newest-first history per channel.
  int coef_m [TAPS];
  int hist_m [CH][TAPS];

  typedef struct {
    int pre;
    int ch;
    int din;
    int exp_ch;
    int exp_data;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      coef_m[k] = 0;
      for (int c = 0; c < CH; c++) hist_m[c][k] = 0;
    end
  endfunction

  function automatic int model_push(input int ch, input int d);
    longint s = 0;
    for (int i = TAPS - 1; i > 0; i--) hist_m[ch][i] = hist_m[ch][i-1];
    hist_m[ch][0] = d;
    for (int k = 0; k < TAPS; k++) s += longint'(coef_m[k]) * longint'(hist_m[ch][k]);
    s = s & ((64'sd1 <<< WO) - 1);
    if (s >= (64'sd1 <<< (WO - 1))) s -= (64'sd1 <<< WO);
    return int'(s);
  endfunction

  task automatic reset_dut(input bit chk);
    rst = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
    in_data = '0; in_ch = '0; coef_addr = '0; coef_data = '0;
    tick();
    if (chk) check("ready_during_reset", in_ready, 0);
    tick();
    rst = 1'b1;
    tick();
    model_reset();
    if (chk) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_busy", busy, 0);
      check("rst_sat_flag", sat_flag, 0);
    end
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we = 1'b1; coef_addr = 2'(a); coef_data = 8'(v);
    tick();
    coef_we = 1'b0;
    coef_m[a] = v;
  endtask

  task automatic load_coefs(input int c [TAPS]);
    for (int k = 0; k < TAPS; k++) write_coef(k, c[k]);
  endtask

  task automatic wait_out();
    r_lat = 1;
    while (!out_valid && r_lat < 20) begin
      tick();
      r_lat++;
    end
    r_data   = int'(out_data);
    r_ch     = int'(out_ch);
    r_data16 = int'(out_data16);
    r_sat16  = int'(sat_flag16);
  endtask

  task automatic send(input int ch, input int d);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    in_valid = 1'b1; in_ch = 1'(ch); in_data = 8'(d);
    tick();
    in_valid = 1'b0;
    wait_out();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    send(v.ch, v.din);
    check({tag, "_data"}, r_data, v.exp_data);
    check({tag, "_ch"}, r_ch, v.exp_ch);
    check({tag, "_latency"}, r_lat, TAPS + 1);
    tick();
    check({tag, "_pulse"}, out_valid, 0);
  endtask

  initial begin
    int acc_t [$];
    int bad;
    int n;
    int exp;

    vt[0]  = '{1, 0,    1, 0,     1};
    vt[1]  = '{0, 0,    0, 0,     2};
    vt[2]  = '{0, 0,    0, 0,     3};
    vt[3]  = '{0, 0,    0, 0,     4};
    vt[4]  = '{0, 0,    0, 0,     0};
    vt[5]  = '{0, 0,    0, 0,     0};
    vt[6]  = '{1, 0,   10, 0,    10};
    vt[7]  = '{0, 1,    5, 1,     5};
    vt[8]  = '{0, 0,    0, 0,    20};
    vt[9]  = '{2, 0, -128, 0, 16384};
    vt[10] = '{0, 0, -128, 0, 32768};
    vt[11] = '{0, 0, -128, 0, 49152};
    vt[12] = '{0, 0, -128, 0, 65536};

    reset_dut(1'b1);

    // Impulse/wrap, channel isolation, signed extremes.
    for (int i = 0; i < 13; i++) begin
      if (vt[i].pre == 1) begin reset_dut(1'b0); load_coefs(c1234); end
      else if (vt[i].pre == 2) begin reset_dut(1'b0); load_coefs(cm128); end
      run_vec(vt[i], $sformatf("vec%0d", i));
    end

    // Overflow on the 16-bit instance.
    reset_dut(1'b0);
    load_coefs(c127);
    send(0, 127);
    send(0, 127);
    check("sat16_second", r_data16, 32258);
    check("sat16_flag_early", r_sat16, 0);
    send(0, 127);
    check("wide_third", r_data, 48387);
`ifdef FIR_SAT_EN
    check("sat16_third", r_data16, 32767);
    check("sat16_flag", r_sat16, 1);
`else
    check("sat16_third", r_data16, -17149);
    check("sat16_flag", r_sat16, 0);
`endif

    // Continuous in_valid: accept spacing and ready during busy.
    reset_dut(1'b0);
    load_coefs(c1234);
    in_valid = 1'b1; in_ch = 1'b0; in_data = '0;
    bad = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (in_ready) acc_t.push_back(cyc);
      if (busy && in_ready) bad++;
      tick();
    end
    in_valid = 1'b0;
    check("ready_low_when_busy", bad, 0);
    check("accept_count", acc_t.size(), 7);
    for (int i = 1; i < acc_t.size(); i++)
      check($sformatf("accept_gap%0d", i), acc_t[i] - acc_t[i-1], TAPS + 2);
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end

    // Coefficient write during MAC is ignored.
    reset_dut(1'b0);
    load_coefs(c1234);
    in_valid = 1'b1; in_ch = 1'b0; in_data = 8'sd1;
    tick();
    in_valid = 1'b0;
    check("guard_busy", busy, 1);
    coef_we = 1'b1; coef_addr = 2'd3; coef_data = 8'sd77;
    tick();
    coef_we = 1'b0;
    wait_out();
    check("guard_out0", r_data, 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      send(0, 0);
      check($sformatf("guard_out%0d", i - 1), r_data, i);
    end

    // Coefficient write coincident with the handshake is used immediately.
    reset_dut(1'b0);
    tick();
    in_valid = 1'b1; in_ch = 1'b1; in_data = 8'sd3;
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd5;
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
    wait_out();
    check("same_cycle_coef_data", r_data, 15);
    check("same_cycle_coef_ch", r_ch, 1);
    tick();

    // Reset during MAC aborts the sample.
    reset_dut(1'b0);
    load_coefs(c1234);
    in_valid = 1'b1; in_ch = 1'b0; in_data = 8'sd9;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("ready_in_mid_reset", in_ready, 0);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < TAPS + 4; i++) begin
      tick();
      if (out_valid) bad++;
    end
    check("abort_no_out_valid", bad, 0);
    check("abort_busy", busy, 0);
    check("abort_out_data", int'(out_data), 0);
    load_coefs(c1234);
    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("after_abort%0d", i));

    // Randomized traffic against the model.
    reset_dut(1'b0);
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < 40; i++) begin
      int ch, d;
      if ($urandom_range(0, 7) == 0)
        write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)) - 128);
      ch  = int'($urandom_range(0, CH - 1));
      d   = int'($urandom_range(0, 255)) - 128;
      exp = model_push(ch, d);
      send(ch, d);
      check($sformatf("rand%0d_data", i), r_data, exp);
      check($sformatf("rand%0d_ch", i), r_ch, ch);
      tick();
    end
    check("rand_sat_flag", sat_flag, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
